ex_operand_ctrl: RTL
====================

Name: ex_operand_ctrl

Overview:
- Sequencing controller for the EX-stage operand path: the ALU B-operand register/immediate select mux and the A/B forwarding muxes.
- Registers ID-stage decode info into an ID/EX control stage and tracks producers in EX/MEM and MEM/WB.
- Generates the EX-stage ALUSrc and forwarding selects, detects load-use hazards, stalls ID/IF and injects a bubble.
- Sits between the decoder and the EX-stage operand muxes of the 5-stage MIPS pipeline.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_AW  source register A.
- id_rt  in  REG_AW  source register B / store data / load dest.
- id_dest  in  REG_AW  resolved write register (rd or rt).
- id_is_imm  in  1  B operand is the sign-extended immediate.
- id_is_store  in  1  store; rt is read as store data.
- id_is_load  in  1  load.
- id_reg_write  in  1  instruction writes the register file.
- flush  in  1  branch/jump redirect: kill the instruction entering EX.
- stall  out  1  hold PC and IF/ID this cycle (combinational).
- ex_valid  out  1  EX holds a real instruction.
- ex_alu_src  out  1  1 = immediate, 0 = register; drives the B-operand select.
- ex_fwd_a  out  2  00 = RF, 01 = EX/MEM result, 10 = MEM/WB result.
- ex_fwd_b  out  2  same encoding, register path only.
- ex_fwd_st  out  2  same encoding, store-data path.
- stall_count  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Reset (async assert, sync release):
  - All ex_* outputs are 0; ex_valid = 0.
  - Internal EX/MEM and MEM/WB trackers (valid, dest, reg_write, load) are cleared.
  - stall_count = 0; FSM = RUN.
- Producer pipeline: each clk the EX tracker moves to MEM, and MEM moves to WB tracking.
- A producer counts for hazard detection or forwarding only if valid, reg_write = 1 and dest != 0.
- Consumers:
  - rs is used when id_valid.
  - rt is used when id_valid and (!id_is_imm or id_is_store).
- Load-use hazard: combinational.
  - Condition: EX tracker is a valid load with dest != 0, and dest matches a used rs or rt.
  - Result: stall = 1.
  - On that edge, EX gets a bubble: ex_valid = 0, all selects 0.
  - The ID instruction is held and re-evaluated next cycle, when the load is in MEM → fwd = 10.
  - Exactly one stall cycle per load-use pair.
- Forward selects: computed from the trackers at ID→EX transfer and registered, so they are valid during the EX cycle.
  - Producer in EX (moving to MEM) → 01.
  - Else producer in MEM (moving to WB) → 10.
  - Else 00. The newest producer wins.
- ex_fwd_b:
  - Forced to 00 when id_is_imm.
  - ex_alu_src = id_is_imm & id_valid.
- ex_fwd_st: nonzero only for stores; selects per rt.
- FSM states:
  - RUN → STALL on a load-use hazard.
  - STALL → RUN unconditionally after 1 cycle.
  - STALL never asserts stall again for the same instruction, because the load has left EX.
- flush:
  - The EX register loads a bubble.
  - Trackers for the flushed slot are cleared.
  - stall is forced 0, so flush wins over a simultaneous hazard.
  - FSM → RUN.
- stall_count: +1 on every cycle with stall = 1; saturates at all-ones with no wrap.
- id_valid = 0: EX receives a bubble and no stall is raised.
- Reset mid-stall: immediate return to reset state; the held instruction is dropped by upstream reset.
- Latency: select outputs are available 1 cycle after ID presents the instruction. There is no combinational path from ID inputs to ex_* outputs.

Test Plan:
- Reset: rst_n low mid-stream with stall active → all outputs 0 immediately, stall_count = 0, no clk needed.
- Back-to-back ALU ops:
  - Stimulus: add $3←$1,$2 then sub $4←$3,$5.
  - Response: second instruction in EX has ex_fwd_a = 01, ex_fwd_b = 00, stall never asserted.
- Load-use:
  - Stimulus: lw $8 then addi $9←$8,4.
  - Response: stall = 1 for exactly 1 cycle; bubble in EX (ex_valid = 0); addi then enters EX with ex_fwd_a = 10, ex_alu_src = 1; stall_count = 1.
- Double producer:
  - Stimulus: add $6; or $6; and $7←$6,$6.
  - Response: ex_fwd_a = ex_fwd_b = 01 (newest wins).
- $zero and immediate:
  - Stimulus: add $0 then add using $0; addi with rt matching the prior dest.
  - Response: fwd = 00 in both cases.
- Flush with hazard:
  - Stimulus: lw $8 then dependent add with flush = 1 in the same cycle.
  - Response: stall = 0, ex_valid = 0 next cycle, stall_count unchanged.
- Saturation: force 2^CNT_W stall cycles → stall_count holds all-ones.

Source files
------------

// File: rtl/ex_operand_ctrl.sv
// EX-stage operand controller: registers ID decode into EX, tracks producers in EX and MEM,
// generates ALUSrc / forwarding selects and handles load-use stalls with a single bubble.
module ex_operand_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_is_imm,
    input  logic              id_is_store,
    input  logic              id_is_load,
    input  logic              id_reg_write,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_alu_src,
    output logic [1:0]        ex_fwd_a,
    output logic [1:0]        ex_fwd_b,
    output logic [1:0]        ex_fwd_st,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic {RUN, HOLD} state_t;

    state_t state_reg, state_next;

    // Instruction currently in EX (also the EX/MEM producer tracker)
    logic              ex_valid_reg;
    logic [REG_AW-1:0] ex_dest_reg;
    logic              ex_wr_reg;
    logic              ex_load_reg;
    logic              ex_alu_src_reg;
    logic [1:0]        ex_fwd_a_reg;
    logic [1:0]        ex_fwd_b_reg;
    logic [1:0]        ex_fwd_st_reg;

    // Instruction currently in MEM (MEM/WB producer tracker)
    logic              mem_valid_reg;
    logic [REG_AW-1:0] mem_dest_reg;
    logic              mem_wr_reg;

    logic [CNT_W-1:0]  stall_count_reg;

    logic              ex_prod;
    logic              mem_prod;
    logic              rt_used;
    logic              hazard;
    logic              load_ex;
    logic [REG_AW-1:0] src [2];
    logic [1:0]        sel [2];

    assign ex_prod  = ex_valid_reg  & ex_wr_reg  & (ex_dest_reg  != '0);
    assign mem_prod = mem_valid_reg & mem_wr_reg & (mem_dest_reg != '0);
    assign rt_used  = id_valid & (~id_is_imm | id_is_store);

    assign src[0] = id_rs;
    assign src[1] = id_rt;

    // Newest producer wins: the EX occupant will sit in EX/MEM when this instruction executes
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sel
            always_comb begin
                sel[gi] = 2'b00;
                if (ex_prod && (ex_dest_reg == src[gi])) begin
                    sel[gi] = 2'b01;
                end else if (mem_prod && (mem_dest_reg == src[gi])) begin
                    sel[gi] = 2'b10;
                end
            end
        end
    endgenerate

    assign hazard = ex_valid_reg & ex_load_reg & (ex_dest_reg != '0) &
                    ((id_valid & (id_rs == ex_dest_reg)) | (rt_used & (id_rt == ex_dest_reg)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     state_next = stall ? HOLD : RUN;
            HOLD:    state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Flush overrides a simultaneous hazard; HOLD never re-stalls the held instruction
    always_comb begin
        stall = 1'b0;
        if (state_reg == RUN) begin
            stall = hazard & ~flush;
        end
    end

    assign load_ex = id_valid & ~stall & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_reg    <= 1'b0;
            ex_dest_reg     <= '0;
            ex_wr_reg       <= 1'b0;
            ex_load_reg     <= 1'b0;
            ex_alu_src_reg  <= 1'b0;
            ex_fwd_a_reg    <= 2'b00;
            ex_fwd_b_reg    <= 2'b00;
            ex_fwd_st_reg   <= 2'b00;
            mem_valid_reg   <= 1'b0;
            mem_dest_reg    <= '0;
            mem_wr_reg      <= 1'b0;
            stall_count_reg <= '0;
        end else begin
            mem_valid_reg <= ex_valid_reg;
            mem_dest_reg  <= ex_dest_reg;
            mem_wr_reg    <= ex_wr_reg;

            if (load_ex) begin
                ex_valid_reg   <= 1'b1;
                ex_dest_reg    <= id_dest;
                ex_wr_reg      <= id_reg_write;
                ex_load_reg    <= id_is_load;
                ex_alu_src_reg <= id_is_imm;
                ex_fwd_a_reg   <= sel[0];
                ex_fwd_b_reg   <= id_is_imm ? 2'b00 : sel[1];
                ex_fwd_st_reg  <= id_is_store ? sel[1] : 2'b00;
            end else begin
                ex_valid_reg   <= 1'b0;
                ex_dest_reg    <= '0;
                ex_wr_reg      <= 1'b0;
                ex_load_reg    <= 1'b0;
                ex_alu_src_reg <= 1'b0;
                ex_fwd_a_reg   <= 2'b00;
                ex_fwd_b_reg   <= 2'b00;
                ex_fwd_st_reg  <= 2'b00;
            end

            if (stall && (stall_count_reg != '1)) begin
                stall_count_reg <= stall_count_reg + 1'b1;
            end
        end
    end

    assign ex_valid    = ex_valid_reg;
    assign ex_alu_src  = ex_alu_src_reg;
    assign ex_fwd_a    = ex_fwd_a_reg;
    assign ex_fwd_b    = ex_fwd_b_reg;
    assign ex_fwd_st   = ex_fwd_st_reg;
    assign stall_count = stall_count_reg;

endmodule
